// File: rtl/telegraph_pkg.sv
// Shared types and defaults for the telegraph serial-to-byte packer.
package telegraph_pkg;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned IDLE_LIMIT_DEFAULT = 15;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned LEN_W              = 4;
  localparam int unsigned CNT_W              = 4;
  localparam int unsigned IDLE_W             = 4;
  localparam int unsigned BITCNT_W           = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } fsmState_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic              last;
  } entry_t;

endpackage

// File: rtl/telegraph_packer_if.sv
// Serial input and packed-byte output bundle of the telegraph packer.
interface telegraph_packer_if;
  import telegraph_pkg::*;

  logic              ClkEn;
  logic              SerIn;
  logic              SerInValid;
  logic [BYTE_W-1:0] ByteOut;
  logic [LEN_W-1:0]  ByteLen;
  logic              ByteLast;
  logic              ByteValid;
  logic              ByteReady;
  logic [CNT_W-1:0]  FifoCnt;
  logic              Overflow;

  // master: the packer; slave: serial source plus byte consumer
  modport master (
    input  ClkEn, SerIn, SerInValid, ByteReady,
    output ByteOut, ByteLen, ByteLast, ByteValid, FifoCnt, Overflow
  );

  modport slave (
    output ClkEn, SerIn, SerInValid, ByteReady,
    input  ByteOut, ByteLen, ByteLast, ByteValid, FifoCnt, Overflow
  );

endinterface

// File: rtl/telegraph_fifo.sv
// Output FIFO of packed entries; head, valid and count are registered.
module telegraph_fifo
  import telegraph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Push,
  input  entry_t           PushEntry,
  input  logic             PopReady,
  output entry_t           HeadEntry,
  output logic             HeadValid,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

  entry_t            mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtrNext;
  logic [ADDR_W-1:0] wrPtrNext;
  logic [CNT_W-1:0]  countNext;
  logic              pop;
  logic              doPush;
  entry_t            headNext;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop       = HeadValid && PopReady;
    doPush    = Push && ((Count < CNT_W'(FIFO_DEPTH)) || pop);
    rdPtrNext = pop ? rdPtr + ADDR_W'(1) : rdPtr;
    wrPtrNext = doPush ? wrPtr + ADDR_W'(1) : wrPtr;
    countNext = Count + CNT_W'(doPush) - CNT_W'(pop);
    headNext  = '0;
    if (countNext != '0) begin
      if (doPush && (wrPtr == rdPtrNext)) begin
        headNext = PushEntry;
      end else begin
        headNext = mem[rdPtrNext];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) begin
      mem[wrPtr] <= PushEntry;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      Count     <= '0;
      HeadEntry <= '0;
      HeadValid <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      rdPtr     <= rdPtrNext;
      wrPtr     <= wrPtrNext;
      Count     <= countNext;
      HeadEntry <= headNext;
      HeadValid <= (countNext != '0);
      if (Push && !doPush) begin
        Overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/telegraph_packer.sv
// Packs enabled serial bits MSB-first into bytes, closes frames on idle timeout
// and queues the resulting entries for a ready/valid consumer.
module telegraph_packer
  import telegraph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned IDLE_LIMIT = IDLE_LIMIT_DEFAULT
) (
  input logic                Clk,
  input logic                Rst,
  telegraph_packer_if.master bus
);

  fsmState_t            state;
  fsmState_t            stateNext;
  logic [BYTE_W-1:0]    sr;
  logic [BYTE_W-1:0]    srNext;
  logic [BITCNT_W-1:0]  bitCnt;
  logic [BITCNT_W-1:0]  bitCntNext;
  logic [IDLE_W-1:0]    idleCnt;
  logic [IDLE_W-1:0]    idleCntNext;
  logic [IDLE_W-1:0]    idleInc;
  entry_t               stage;
  entry_t               stageNext;
  logic                 stageFull;
  logic                 stageFullNext;
  logic                 accept;
  logic                 pushReq;
  entry_t               pushEntry;
  logic [BYTE_W-1:0]    partialData;

  entry_t               head;
  logic                 headValid;
  logic [CNT_W-1:0]     fifoCnt;
  logic                 overflow;

  // Next-state and push decision; accept and timeout are mutually exclusive.
  always_comb begin
    stateNext     = state;
    srNext        = sr;
    bitCntNext    = bitCnt;
    idleCntNext   = idleCnt;
    stageNext     = stage;
    stageFullNext = stageFull;
    pushReq       = 1'b0;
    pushEntry     = '0;
    accept        = bus.ClkEn && bus.SerInValid;
    idleInc       = idleCnt + IDLE_W'(1);
    partialData   = sr << (LEN_W'(BYTE_W) - LEN_W'(bitCnt));

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = RECV;
        end
      end
      RECV: begin
        if (bus.ClkEn && !bus.SerInValid) begin
          idleCntNext = idleInc;
          if (idleInc == IDLE_W'(IDLE_LIMIT)) begin
            if (bitCnt != '0) begin
              pushReq   = 1'b1;
              pushEntry = '{data: partialData, len: LEN_W'(bitCnt), last: 1'b1};
            end else if (stageFull) begin
              pushReq        = 1'b1;
              pushEntry      = stage;
              pushEntry.last = 1'b1;
            end
            stateNext     = IDLE;
            srNext        = '0;
            bitCntNext    = '0;
            idleCntNext   = '0;
            stageNext     = '0;
            stageFullNext = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (accept) begin
      srNext      = {sr[BYTE_W-2:0], bus.SerIn};
      bitCntNext  = bitCnt + BITCNT_W'(1);
      idleCntNext = '0;
      // The staged byte is known not to be final once another bit arrives.
      if (stageFull) begin
        pushReq        = 1'b1;
        pushEntry      = stage;
        pushEntry.last = 1'b0;
        stageFullNext  = 1'b0;
      end
      if (bitCnt == BITCNT_W'(BYTE_W - 1)) begin
        stageNext     = '{data: {sr[BYTE_W-2:0], bus.SerIn}, len: LEN_W'(BYTE_W), last: 1'b0};
        stageFullNext = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      sr        <= '0;
      bitCnt    <= '0;
      idleCnt   <= '0;
      stage     <= '0;
      stageFull <= 1'b0;
    end else begin
      state     <= stateNext;
      sr        <= srNext;
      bitCnt    <= bitCntNext;
      idleCnt   <= idleCntNext;
      stage     <= stageNext;
      stageFull <= stageFullNext;
    end
  end

  telegraph_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) uFifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .Push      (pushReq),
    .PushEntry (pushEntry),
    .PopReady  (bus.ByteReady),
    .HeadEntry (head),
    .HeadValid (headValid),
    .Count     (fifoCnt),
    .Overflow  (overflow)
  );

  assign bus.ByteOut   = head.data;
  assign bus.ByteLen   = head.len;
  assign bus.ByteLast  = head.last;
  assign bus.ByteValid = headValid;
  assign bus.FifoCnt   = fifoCnt;
  assign bus.Overflow  = overflow;

endmodule

// File: tb/tb_telegraph_packer.sv
// Directed scoreboard bench for telegraph_packer.
module tb_telegraph_packer;
  import telegraph_pkg::*;

  logic   Clk;
  logic   Rst;
  int     testCnt;
  int     failCnt;
  entry_t sb[$];

  telegraph_packer_if bus ();

  telegraph_packer #(
    .FIFO_DEPTH(4),
    .IDLE_LIMIT(15)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge; a pending handshake is scored before the edge.
  task automatic step(input logic ce, input logic sin, input logic sv);
    entry_t exp;
    bus.ClkEn      = ce;
    bus.SerIn      = sin;
    bus.SerInValid = sv;
    #1;
    if (bus.ByteValid && bus.ByteReady) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("pop_data", 32'(bus.ByteOut), 32'(exp.data));
        check("pop_len",  32'(bus.ByteLen), 32'(exp.len));
        check("pop_last", 32'(bus.ByteLast), 32'(exp.last));
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic sendBits(input logic [7:0] data, input int n);
    logic [7:0] d;
    d = data;
    for (int i = n - 1; i >= 0; i--) step(1'b1, d[i], 1'b1);
  endtask

  task automatic expectEntry(input logic [7:0] data, input logic [3:0] len, input logic last);
    sb.push_back('{data: data, len: len, last: last});
  endtask

  initial begin
    logic sawValid;
    testCnt        = 0;
    failCnt        = 0;
    Rst            = 1'b0;
    bus.ClkEn      = 1'b0;
    bus.SerIn      = 1'b0;
    bus.SerInValid = 1'b0;
    bus.ByteReady  = 1'b1;
    @(negedge Clk);
    @(negedge Clk);

    check("rst_byteout",   32'(bus.ByteOut), 32'h0);
    check("rst_bytelen",   32'(bus.ByteLen), 32'h0);
    check("rst_bytelast",  32'(bus.ByteLast), 32'h0);
    check("rst_bytevalid", 32'(bus.ByteValid), 32'h0);
    check("rst_fifocnt",   32'(bus.FifoCnt), 32'h0);
    check("rst_overflow",  32'(bus.Overflow), 32'h0);
    Rst = 1'b1;
    idle(2);

    // Full byte closed by timeout.
    expectEntry(8'hBF, 4'd8, 1'b1);
    sendBits(8'hBF, 8);
    idle(14);
    check("t1_no_early", 32'(bus.ByteValid), 32'h0);
    idle(1);
    check("t1_valid",   32'(bus.ByteValid), 32'h1);
    check("t1_fifocnt", 32'(bus.FifoCnt), 32'h1);
    idle(2);
    check("t1_drained", 32'(bus.ByteValid), 32'h0);

    // Partial byte is left-aligned.
    expectEntry(8'hA0, 4'd3, 1'b1);
    sendBits(8'h05, 3);
    idle(17);

    // Back-to-back bytes: first closed by the next bit, second by timeout.
    expectEntry(8'hBF, 4'd8, 1'b0);
    expectEntry(8'h0E, 4'd8, 1'b1);
    sendBits(8'hBF, 8);
    sendBits(8'h0E, 8);
    idle(17);
    check("t3_sb_empty", 32'(sb.size()), 32'h0);

    // Overflow with a stalled consumer; fifth entry dropped.
    bus.ByteReady = 1'b0;
    expectEntry(8'h11, 4'd8, 1'b0);
    expectEntry(8'h22, 4'd8, 1'b0);
    expectEntry(8'h33, 4'd8, 1'b0);
    expectEntry(8'h44, 4'd8, 1'b0);
    sendBits(8'h11, 8);
    sendBits(8'h22, 8);
    sendBits(8'h33, 8);
    sendBits(8'h44, 8);
    sendBits(8'h55, 8);
    idle(16);
    check("t4_fifocnt",  32'(bus.FifoCnt), 32'h4);
    check("t4_overflow", 32'(bus.Overflow), 32'h1);
    check("t4_head",     32'(bus.ByteOut), 32'h11);
    bus.ByteReady = 1'b1;
    idle(6);
    check("t4_sb_empty",       32'(sb.size()), 32'h0);
    check("t4_fifocnt_drain",  32'(bus.FifoCnt), 32'h0);
    check("t4_overflow_stick", 32'(bus.Overflow), 32'h1);

    // ClkEn low freezes bit acceptance and the idle counter.
    expectEntry(8'hC0, 4'd3, 1'b1);
    sendBits(8'h06, 3);
    idle(10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    idle(4);
    check("t5_frozen", 32'(bus.ByteValid), 32'h0);
    idle(1);
    check("t5_valid", 32'(bus.ByteValid), 32'h1);
    idle(2);
    check("t5_sb_empty", 32'(sb.size()), 32'h0);

    // Reset mid-frame discards the partial byte.
    sendBits(8'h1B, 5);
    Rst = 1'b0;
    #1;
    check("t6_rst_valid",    32'(bus.ByteValid), 32'h0);
    check("t6_rst_overflow", 32'(bus.Overflow), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      sawValid = sawValid | bus.ByteValid;
    end
    check("t6_no_valid", 32'(sawValid), 32'h0);
    check("t6_fifocnt",  32'(bus.FifoCnt), 32'h0);
    check("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
